// File: rtl/tur.sv
// -----------------------------------------------------------------------------
// tur -- two-piece board scoring stage
//
// Scores two pieces on a 4x4 board with a fixed cell-value table, sums the two
// values and flags whether the sum reaches THRESH. Results are registered, so
// they appear one cycle after a valid sample and hold while in_valid is low.
//
// Parameters
//   THRESH     combined-score threshold for B (B = sum >= THRESH)
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  sample X1/Y1/X2/Y2 on this edge
//   X1, Y1     in   2  piece 1 column / row
//   X2, Y2     in   2  piece 2 column / row
//   out_valid  out  1  registered copy of in_valid
//   p1, p2     out  2  cell values of piece 1 / piece 2
//   sum        out  3  p1 + p2 (0..6)
//   B          out  1  sum >= THRESH
// -----------------------------------------------------------------------------
module tur #(
    parameter int unsigned THRESH = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] X1,
    input  logic [1:0] Y1,
    input  logic [1:0] X2,
    input  logic [1:0] Y2,
    output logic       out_valid,
    output logic [1:0] p1,
    output logic [1:0] p2,
    output logic [2:0] sum,
    output logic       B
);

    // Fixed cell-value ROM, indexed {x, y}.
    //   x0: 0 0 0 0 | x1: 0 1 2 1 | x2: 0 2 3 2 | x3: 0 1 2 1
    function automatic logic [1:0] cell_value(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] v;
        case ({x, y})
            4'b01_01: v = 2'd1;
            4'b01_10: v = 2'd2;
            4'b01_11: v = 2'd1;
            4'b10_01: v = 2'd2;
            4'b10_10: v = 2'd3;
            4'b10_11: v = 2'd2;
            4'b11_01: v = 2'd1;
            4'b11_10: v = 2'd2;
            4'b11_11: v = 2'd1;
            default:  v = 2'd0;  // any coordinate on row/column 0
        endcase
        return v;
    endfunction

    logic       out_valid_q;
    logic [1:0] p1_q, p1_d;
    logic [1:0] p2_q, p2_d;
    logic [2:0] sum_q, sum_d;
    logic       b_q, b_d;

    always_comb begin
        p1_d  = cell_value(X1, Y1);
        p2_d  = cell_value(X2, Y2);
        // Widen before adding so 3+3 lands on 6 rather than wrapping.
        sum_d = {1'b0, p1_d} + {1'b0, p2_d};
        b_d   = (32'(sum_d) >= THRESH);
    end

    // Scores only load on a valid sample; otherwise the last result is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            p1_q        <= 2'd0;
            p2_q        <= 2'd0;
            sum_q       <= 3'd0;
            b_q         <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                p1_q  <= p1_d;
                p2_q  <= p2_d;
                sum_q <= sum_d;
                b_q   <= b_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign p1        = p1_q;
    assign p2        = p2_q;
    assign sum       = sum_q;
    assign B         = b_q;

endmodule

// File: tb/tb_tur.sv
// -----------------------------------------------------------------------------
// tb_tur -- self-checking bench for tur
//
// Directed steps plus exhaustive and randomized sweeps, each compared against
// a reference model that scores cells from the arithmetic rule
// P = 0 on row/column 0, else c(x)+c(y)-1 with c(2)=2 and c(1)=c(3)=1.
// -----------------------------------------------------------------------------
module tb_tur;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] X1, Y1, X2, Y2;
    logic       out_valid;
    logic [1:0] p1, p2;
    logic [2:0] sum;
    logic       B;

    int checks;
    int errors;

    // Reference model state
    int exp_ov, exp_p1, exp_p2, exp_sum, exp_b;

    tur #(.THRESH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .X1        (X1),
        .Y1        (Y1),
        .X2        (X2),
        .Y2        (Y2),
        .out_valid (out_valid),
        .p1        (p1),
        .p2        (p2),
        .sum       (sum),
        .B         (B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfac(input int v);
        return (v == 2) ? 2 : 1;
    endfunction

    function automatic int pval(input int x, input int y);
        if (x == 0 || y == 0) return 0;
        return cfac(x) + cfac(y) - 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
        chk({tag, ".p1"},        32'(p1),        32'(exp_p1));
        chk({tag, ".p2"},        32'(p2),        32'(exp_p2));
        chk({tag, ".sum"},       32'(sum),       32'(exp_sum));
        chk({tag, ".B"},         32'(B),         32'(exp_b));
    endtask

    task automatic model_reset();
        exp_ov = 0; exp_p1 = 0; exp_p2 = 0; exp_sum = 0; exp_b = 0;
    endtask

    // One transaction: drive on the falling edge, check 1 ns after the rising edge.
    task automatic step(input string tag, input bit v, input int x1, input int y1,
                        input int x2, input int y2);
        @(negedge clk);
        in_valid = v;
        X1 = 2'(x1); Y1 = 2'(y1); X2 = 2'(x2); Y2 = 2'(y2);
        @(posedge clk);
        #1;
        exp_ov = v ? 1 : 0;
        if (v) begin
            exp_p1  = pval(x1, y1);
            exp_p2  = pval(x2, y2);
            exp_sum = exp_p1 + exp_p2;
            exp_b   = (exp_sum >= 5) ? 1 : 0;
        end
        chk_all(tag);
        $display("%s v=%0d (%0d,%0d)+(%0d,%0d) -> ov=%0d p1=%0d p2=%0d sum=%0d B=%0d",
                 tag, v, x1, y1, x2, y2, out_valid, p1, p2, sum, B);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        X1 = 2'd0; Y1 = 2'd0; X2 = 2'd0; Y2 = 2'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_release_idle");

        // Directed corner cases, also pinned to literal values
        step("d22_22", 1'b1, 2, 2, 2, 2);
        chk("d22_22.sum_lit", 32'(sum), 32'd6);
        chk("d22_22.B_lit",   32'(B),   32'd1);
        step("d22_12", 1'b1, 2, 2, 1, 2);
        chk("d22_12.sum_lit", 32'(sum), 32'd5);
        chk("d22_12.B_lit",   32'(B),   32'd1);
        step("d22_11", 1'b1, 2, 2, 1, 1);
        chk("d22_11.sum_lit", 32'(sum), 32'd4);
        chk("d22_11.B_lit",   32'(B),   32'd0);
        step("d03_30", 1'b1, 0, 3, 3, 0);
        chk("d03_30.sum_lit", 32'(sum), 32'd0);

        // Hold: a valid sample followed by an idle cycle with new coordinates
        step("hold_load", 1'b1, 2, 2, 2, 3);
        step("hold_idle", 1'b0, 1, 1, 0, 0);
        chk("hold.sum_lit", 32'(sum), 32'd5);
        chk("hold.B_lit",   32'(B),   32'd1);
        chk("hold.ov_lit",  32'(out_valid), 32'd0);

        // Exhaustive, back-to-back valid samples
        for (int i = 0; i < 256; i++) begin
            step("exh", 1'b1, (i >> 6) & 3, (i >> 4) & 3, (i >> 2) & 3, i & 3);
        end

        // Randomized mix of valid and idle cycles
        for (int i = 0; i < 200; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        end

        // Asynchronous reset mid-stream with a sample in flight
        step("pre_rst", 1'b1, 2, 2, 2, 2);
        @(negedge clk);
        in_valid = 1'b1;
        X1 = 2'd2; Y1 = 2'd2; X2 = 2'd1; Y2 = 2'd2;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        @(posedge clk);
        #1;
        chk_all("rst_held");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk_all("rst_released");
        step("post_rst", 1'b1, 2, 3, 2, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
